intra_substi_opt_gen: RTL and testbench



---
 rtl/intra_substi_opt_gen_if.sv | 41 ++++
 rtl/intra_substi_opt_gen.sv | 185 ++++++++++++++++++
 tb/tb_intra_substi_opt_gen.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/intra_substi_opt_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : intra_substi_opt_gen_if
//  Brief    : Request and beat-output bundle of the intra reference-sample
//             substitution option generator. The master side issues TU
//             requests and accepts beats. The slave side is the generator.
//  Revision : 1.0  initial release
// ============================================================================
interface intra_substi_opt_gen_if #(
  parameter int NGRP  = 32,
  parameter int NBANK = 8
);
  localparam int OPTW = 2 + 3 * NBANK;
  localparam int BIW  = $clog2(NGRP / NBANK);

  // Request side
  logic             start;
  logic [2:0]       log2_size;
  logic             is_cr;
  logic [NGRP-1:0]  avail;
  logic             tl_avail;
  logic             busy;

  // Beat output side
  logic             opt_valid;
  logic             opt_ready;
  logic [OPTW-1:0]  substi_opt;
  logic [BIW-1:0]   beat_idx;
  logic             last;

  modport master (
    output start, log2_size, is_cr, avail, tl_avail, opt_ready,
    input  busy, opt_valid, substi_opt, beat_idx, last
  );

  modport slave (
    input  start, log2_size, is_cr, avail, tl_avail, opt_ready,
    output busy, opt_valid, substi_opt, beat_idx, last
  );
endinterface
`default_nettype wire

// File: rtl/intra_substi_opt_gen.sv
`default_nettype none
// ============================================================================
//  Module   : intra_substi_opt_gen
//  Brief    : Builds the per-beat substitution-option word for one TU
//             reference line. Each bank gets a 3-bit option that says how its
//             group is filled: pass-through, first available group's sample,
//             the previous group's last sample, or the mid-grey value.
//  Revision : 1.0  initial release
// ============================================================================
module intra_substi_opt_gen #(
  parameter int NGRP  = 32,
  parameter int NBANK = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  intra_substi_opt_gen_if.slave bus
);

  localparam int GW         = $clog2(NGRP) + 1;   // holds 0..NGRP inclusive
  localparam int BIW        = $clog2(NGRP / NBANK);
  localparam int LOG2_MAX   = $clog2(NGRP);
  localparam int LOG2_NBANK = $clog2(NBANK);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  localparam logic [2:0] OPT_PASS  = 3'd0;
  localparam logic [2:0] OPT_FIRST = 3'd2;
  localparam logic [2:0] OPT_PREV  = 3'd3;
  localparam logic [2:0] OPT_MID   = 3'd4;

  logic [1:0]      state_q, state_d;
  logic [2:0]      log2_q, log2_d;
  logic            cr_q, cr_d;
  logic [NGRP-1:0] avail_q, avail_d;
  logic            tl_q, tl_d;
  logic [GW-1:0]   first_q, first_d;
  logic            none_q, none_d;
  logic [BIW-1:0]  beat_q, beat_d;

  logic [2:0]         log2_in;
  logic [NGRP-1:0]    mask_in;
  logic [GW-1:0]      grp_cnt;
  logic [GW-1:0]      first_found;
  logic [BIW-1:0]     last_beat;
  logic [BIW-1:0]     topl_beat;
  logic [3*NBANK-1:0] opt_word;
  logic               opt_valid;
  logic               topl_sub;

  // Clamp the requested size into the supported range so the group count
  // can never overflow or collapse to zero.
  always_comb begin
    log2_in = bus.log2_size;
    if (bus.log2_size < 3'd2)
      log2_in = 3'd2;
    else if (int'(bus.log2_size) > LOG2_MAX)
      log2_in = 3'(LOG2_MAX);
  end

  // Availability mask for the incoming request: groups at or beyond G are unavailable.
  always_comb begin
    mask_in = '0;
    for (int i = 0; i < NGRP; i++)
      if (i < (1 << int'(log2_in)))
        mask_in[i] = 1'b1;
  end

  // Size-derived quantities of the latched request.
  always_comb begin
    grp_cnt   = GW'(1) << log2_q;
    last_beat = '0;
    if (int'(log2_q) > LOG2_NBANK)
      last_beat = BIW'((1 << (int'(log2_q) - LOG2_NBANK)) - 1);
    topl_beat = BIW'(((1 << int'(log2_q)) / 2 - 1) / NBANK);
  end

  // Lowest-index available group; G when none is available.
  always_comb begin
    first_found = grp_cnt;
    for (int i = NGRP - 1; i >= 0; i--)
      if (avail_q[i])
        first_found = GW'(i);
  end

  // Per-bank option for global group 8*beat + bank.
  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [GW-1:0] grp;
    logic [2:0]    opt;

    assign grp = GW'(int'(beat_q) * NBANK + b);

    // Option priority: outside TU, nothing available, own group, before first, after first.
    always_comb begin
      opt = OPT_PASS;
      if (grp >= grp_cnt)
        opt = OPT_PASS;
      else if (none_q)
        opt = OPT_MID;
      else if (avail_q[grp[GW-2:0]])
        opt = OPT_PASS;
      else if (grp < first_q)
        opt = OPT_FIRST;
      else
        opt = OPT_PREV;
    end

    assign opt_word[3*(NBANK-1-b) +: 3] = opt;
  end

  assign opt_valid      = (state_q == S_EMIT);
  assign topl_sub       = !tl_q && (beat_q == topl_beat);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.opt_valid  = opt_valid;
  assign bus.beat_idx   = beat_q;
  assign bus.last       = opt_valid && (beat_q == last_beat);
  assign bus.substi_opt = opt_valid ? {cr_q, topl_sub, opt_word} : '0;

  // Request latch, scan and beat sequencing.
  always_comb begin
    state_d = state_q;
    log2_d  = log2_q;
    cr_d    = cr_q;
    avail_d = avail_q;
    tl_d    = tl_q;
    first_d = first_q;
    none_d  = none_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SCAN;
          log2_d  = log2_in;
          cr_d    = bus.is_cr;
          avail_d = bus.avail & mask_in;
          tl_d    = bus.tl_avail;
          beat_d  = '0;
        end
      end
      S_SCAN: begin
        first_d = first_found;
        none_d  = (avail_q == '0) && !tl_q;
        beat_d  = '0;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (bus.opt_ready) begin
          if (beat_q == last_beat) begin
            state_d = S_IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any TU in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      log2_q  <= 3'd2;
      cr_q    <= 1'b0;
      avail_q <= '0;
      tl_q    <= 1'b0;
      first_q <= '0;
      none_q  <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      log2_q  <= log2_d;
      cr_q    <= cr_d;
      avail_q <= avail_d;
      tl_q    <= tl_d;
      first_q <= first_d;
      none_q  <= none_d;
      beat_q  <= beat_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_intra_substi_opt_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_intra_substi_opt_gen
//  Brief    : Self-checking bench for intra_substi_opt_gen. Directed cases
//             followed by randomized TUs, all compared to a reference model
//             that derives each option word from the substitution rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_intra_substi_opt_gen;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  intra_substi_opt_gen_if bus ();

  intra_substi_opt_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: option word for one beat, straight from the substitution rules.
  function automatic logic [25:0] ref_word(input int l2, input bit cr,
                                           input logic [31:0] av, input bit tl,
                                           input int beat);
    int          g_cnt;
    int          first;
    int          g;
    bit          none;
    logic [31:0] m;
    logic [2:0]  o;
    logic [25:0] w;
    g_cnt = 1 << l2;
    m = '0;
    for (int i = 0; i < g_cnt; i++) m[i] = av[i];
    first = g_cnt;
    for (int i = 0; i < g_cnt; i++)
      if (m[i] && first == g_cnt) first = i;
    none = (m == 0) && !tl;
    w = '0;
    w[25] = cr;
    w[24] = !tl && (((g_cnt / 2) - 1) / 8 == beat);
    for (int bank = 0; bank < 8; bank++) begin
      g = 8 * beat + bank;
      if (g >= g_cnt)     o = 3'd0;
      else if (none)      o = 3'd4;
      else if (m[g])      o = 3'd0;
      else if (g < first) o = 3'd2;
      else                o = 3'd3;
      w[23 - 3 * bank -: 3] = o;
    end
    return w;
  endfunction

  // Issue one TU and check every presented beat against the model.
  //   stall0    : ready forced low for this many cycles at the first beat
  //   rnd       : random ready after the forced stall, else always ready
  //   poke      : pulse start with different inputs during the stall
  //   end_start : raise start in the cycle of the final handshake
  task automatic run_tu(input string tag, input int l2, input bit cr,
                        input logic [31:0] av, input bit tl, input int stall0,
                        input bit rnd, input bit poke, input bit end_start);
    int beats;
    int b;
    int cyc;
    bit rdy;
    beats = (1 << l2) / 8;
    if (beats < 1) beats = 1;
    bus.start     = 1'b1;
    bus.log2_size = 3'(l2);
    bus.is_cr     = cr;
    bus.avail     = av;
    bus.tl_avail  = tl;
    bus.opt_ready = 1'b0;
    tick();
    bus.start = 1'b0;
    check({tag, ".scan_valid"}, 32'(bus.opt_valid), 32'd0);
    check({tag, ".scan_busy"}, 32'(bus.busy), 32'd1);
    tick();
    b   = 0;
    cyc = 0;
    while (b < beats && cyc < 200) begin
      check({tag, ".valid"}, 32'(bus.opt_valid), 32'd1);
      check({tag, ".word"}, 32'(bus.substi_opt), 32'(ref_word(l2, cr, av, tl, b)));
      check({tag, ".beat_idx"}, 32'(bus.beat_idx), 32'(b));
      check({tag, ".last"}, 32'(bus.last), 32'(b == beats - 1));
      if (cyc < stall0)   rdy = 1'b0;
      else if (rnd)       rdy = ($urandom_range(0, 3) != 0);
      else                rdy = 1'b1;
      bus.opt_ready = rdy;
      if (poke && cyc == 1) begin
        bus.start     = 1'b1;
        bus.log2_size = 3'd5;
        bus.is_cr     = !cr;
        bus.avail     = ~av;
        bus.tl_avail  = !tl;
      end
      if (end_start && rdy && b == beats - 1) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      if (rdy) b++;
      cyc++;
    end
    check({tag, ".timeout"}, 32'(cyc < 200), 32'd1);
    bus.opt_ready = 1'b0;
    check({tag, ".done_busy"}, 32'(bus.busy), 32'd0);
    check({tag, ".done_valid"}, 32'(bus.opt_valid), 32'd0);
    check({tag, ".done_word"}, 32'(bus.substi_opt), 32'd0);
  endtask

  initial begin
    logic [31:0] av;
    int          l2;
    n_cmp = 0;
    n_err = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.log2_size = 3'd2;
    bus.is_cr     = 1'b0;
    bus.avail     = '0;
    bus.tl_avail  = 1'b0;
    bus.opt_ready = 1'b0;
    tick();
    tick();
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.valid", 32'(bus.opt_valid), 32'd0);
    check("rst.word", 32'(bus.substi_opt), 32'd0);
    check("rst.beat_idx", 32'(bus.beat_idx), 32'd0);
    check("rst.last", 32'(bus.last), 32'd0);
    rst = 1'b0;
    tick();

    // Ready while idle must not start anything.
    bus.opt_ready = 1'b1;
    tick();
    tick();
    check("idle_ready.busy", 32'(bus.busy), 32'd0);
    check("idle_ready.valid", 32'(bus.opt_valid), 32'd0);
    bus.opt_ready = 1'b0;

    // Reset in the middle of a stalled 32x32 emit.
    bus.start     = 1'b1;
    bus.log2_size = 3'd5;
    bus.avail     = 32'hFFFF00FF;
    bus.tl_avail  = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    check("midrst.pre_valid", 32'(bus.opt_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("midrst.valid", 32'(bus.opt_valid), 32'd0);
    check("midrst.busy", 32'(bus.busy), 32'd0);
    check("midrst.word", 32'(bus.substi_opt), 32'd0);
    rst = 1'b0;
    tick();
    check("midrst.still_idle", 32'(bus.opt_valid), 32'd0);

    run_tu("post_rst",   5, 1'b0, 32'hFFFF00FF, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run_tu("all_avail8", 3, 1'b0, 32'h000000FF, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    run_tu("f4_8",       3, 1'b0, 32'h000000F0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    run_tu("hole32",     5, 1'b0, 32'hFFFF00FF, 1'b0, 2, 1'b1, 1'b0, 1'b0);
    run_tu("none16",     4, 1'b1, 32'h00000000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run_tu("stall4",     2, 1'b0, 32'h00000005, 1'b1, 3, 1'b0, 1'b1, 1'b0);
    run_tu("mask4",      2, 1'b1, 32'hFFFFFFF2, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Start raised during the final handshake is dropped; the next TU starts from idle.
    run_tu("end_start",  4, 1'b0, 32'h0000F00F, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    run_tu("b2b",        4, 1'b1, 32'h00001100, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      l2 = int'($urandom_range(2, 5));
      case ($urandom_range(0, 3))
        0:       av = $urandom();
        1:       av = $urandom() & $urandom();
        2:       av = ~(32'hFFFFFFFF >> $urandom_range(0, 31));
        default: av = $urandom() | $urandom();
      endcase
      if ((av & ((64'd1 << (1 << l2)) - 64'd1)) == 0)
        run_tu("rand", l2, 1'($urandom_range(0, 1)), av, 1'b0, int'($urandom_range(0, 2)), 1'b1, 1'b0, 1'b0);
      else
        run_tu("rand", l2, 1'($urandom_range(0, 1)), av, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b1, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
